fetch_pc_gen: RTL and testbench

Parametrised program-counter and fetch-request generator for the core's front end. Holds the architectural fetch PC and issues one request at a time to instruction memory over a req/gnt handshake. Applies control-transfer redirects from execute (jump, taken branch, trap) with fixed priority, and queues a redirect that arrives while a request is still waiting for its grant. Sits between the decoder/ALU redirect sources and the instruction-memory port.

---
 rtl/fetch_pc_gen.sv | 198 +++++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//   Front-end program-counter and fetch-request generator. Holds the fetch
//   PC, issues one instruction-memory request at a time over req/gnt, and
//   applies control-transfer redirects (trap > jump > taken branch). A
//   redirect arriving while a request waits for its grant is parked in a
//   one-entry pending register and committed at the grant.
//
//   Optional feature macro: PC_RVC_EN
//     defined   : sequential step is 2 when step2_i=1, else 4; only target
//                 bit 0 is checked for alignment.
//     undefined : step2_i ignored, step always 4, target[1:0] must be 0.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   stall_i              decode back-pressure, blocks the next request
//   ctrl_transfer_sel_i  0 NONE, 1 JUMP, 2 BRANCH, 3 treated as NONE
//   branch_tkn_i         qualifies BRANCH
//   pc_ex_i, offset_i    branch base and offset
//   tgt_addr_i           jump target (bit 0 forced to 0)
//   trap_i, trap_vec_i   trap pulse and trap target (never alignment checked)
//   step2_i              current fetch is a 16-bit instruction
//   imem_req_o           fetch request valid
//   imem_gnt_i           memory accepts the request this cycle
//   pc_o, pc_plus4_o     fetch address and fetch address + 4
//   flush_o              one-cycle pulse after a redirect lands in pc_o
//   misaligned_o         one-cycle pulse after a dropped misaligned redirect
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [1:0]      ctrl_transfer_sel_i,
  input  logic            branch_tkn_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] tgt_addr_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            step2_i,
  output logic            imem_req_o,
  input  logic            imem_gnt_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            flush_o,
  output logic            misaligned_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            flush_nxt;

  logic            pend_vld, pend_vld_nxt;
  logic            pend_trap, pend_trap_nxt;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;

  logic            redir_vld;
  logic            redir_trap;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic            redir_ok;
  logic            new_wins;
  logic            commit_vld;
  logic [XLEN-1:0] commit_tgt;
  logic            completion;
  logic [XLEN-1:0] step;

  // Bits that are intentionally not consumed in every build.
  logic            unused_bits;
  assign unused_bits = ^{step2_i, tgt_addr_i[0]};

  function automatic logic addr_misaligned(input logic [XLEN-1:0] a);
`ifdef PC_RVC_EN
    return (a[1:0] & 2'b01) != 2'b00;
`else
    return a[1:0] != 2'b00;
`endif
  endfunction

  function automatic logic [XLEN-1:0] seq_step(input logic half);
`ifdef PC_RVC_EN
    return half ? XLEN'(2) : XLEN'(4);
`else
    return (half & 1'b0) ? XLEN'(2) : XLEN'(4);
`endif
  endfunction

  // ---- redirect selection and alignment screening ----
  always_comb begin
    redir_vld  = 1'b0;
    redir_trap = 1'b0;
    redir_tgt  = '0;
    if (trap_i) begin
      redir_vld  = 1'b1;
      redir_trap = 1'b1;
      redir_tgt  = trap_vec_i;
    end else if (ctrl_transfer_sel_i == SEL_JUMP) begin
      redir_vld  = 1'b1;
      redir_tgt  = {tgt_addr_i[XLEN-1:1], 1'b0};
    end else if (ctrl_transfer_sel_i == SEL_BRANCH && branch_tkn_i) begin
      redir_vld  = 1'b1;
      redir_tgt  = pc_ex_i + offset_i;
    end
  end

  assign redir_bad = redir_vld & ~redir_trap & addr_misaligned(redir_tgt);
  assign redir_ok  = redir_vld & ~redir_bad;

  // A fresh redirect replaces the parked one unless that would let a
  // non-trap displace a trap.
  assign new_wins   = redir_ok & ~(pend_vld & pend_trap & ~redir_trap);
  assign commit_vld = redir_ok | pend_vld;
  assign commit_tgt = new_wins ? redir_tgt : pend_tgt;

  assign imem_req_o = (state == ST_RUN);
  assign completion = imem_req_o & imem_gnt_i;
  assign step       = seq_step(step2_i);
  assign pc_plus4_o = pc_o + XLEN'(4);

  // ---- next-state / next-pc ----
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_o;
    flush_nxt     = 1'b0;
    pend_vld_nxt  = pend_vld;
    pend_trap_nxt = pend_trap;
    pend_tgt_nxt  = pend_tgt;
    unique case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
        if (redir_ok) begin
          pc_nxt    = redir_tgt;
          flush_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (completion) begin
          pc_nxt       = commit_vld ? commit_tgt : pc_o + step;
          flush_nxt    = commit_vld;
          pend_vld_nxt = 1'b0;
          state_nxt    = stall_i ? ST_HALT : ST_RUN;
        end else if (new_wins) begin
          pend_vld_nxt  = 1'b1;
          pend_trap_nxt = redir_trap;
          pend_tgt_nxt  = redir_tgt;
        end
      end
      ST_HALT: begin
        if (redir_ok) begin
          pc_nxt    = redir_tgt;
          flush_nxt = 1'b1;
        end
        if (!stall_i) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt    = ST_BOOT;
        pend_vld_nxt = 1'b0;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BOOT;
      pc_o         <= RESET_ADDR;
      flush_o      <= 1'b0;
      misaligned_o <= 1'b0;
      pend_vld     <= 1'b0;
      pend_trap    <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_o         <= pc_nxt;
      flush_o      <= flush_nxt;
      misaligned_o <= redir_bad;
      pend_vld     <= pend_vld_nxt;
      pend_trap    <= pend_trap_nxt;
    end
  end

  // Pending target is only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    pend_tgt <= pend_tgt_nxt;
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Self-checking bench for fetch_pc_gen (XLEN=32, RESET_ADDR=0x100).
//   Directed scenarios followed by randomized traffic, all compared against
//   a transaction-level reference model of the fetch front end.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [1:0]  ctrl_transfer_sel_i;
  logic        branch_tkn_i;
  logic [31:0] pc_ex_i, offset_i, tgt_addr_i, trap_vec_i;
  logic        trap_i, step2_i, imem_gnt_i;
  logic        imem_req_o, flush_o, misaligned_o;
  logic [31:0] pc_o, pc_plus4_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_gen #(.XLEN(32), .RESET_ADDR(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .ctrl_transfer_sel_i(ctrl_transfer_sel_i), .branch_tkn_i(branch_tkn_i),
    .pc_ex_i(pc_ex_i), .offset_i(offset_i), .tgt_addr_i(tgt_addr_i),
    .trap_i(trap_i), .trap_vec_i(trap_vec_i), .step2_i(step2_i),
    .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .flush_o(flush_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  // Reference model: front end is booting, fetching (request outstanding)
  // or halted; at most one deferred redirect is remembered.
  typedef enum int {PH_BOOT, PH_FETCH, PH_HALT} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc;
  bit          m_flush, m_mis;
  logic [31:0] defer_addr[$];
  bit          defer_is_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_BOOT;
    m_pc    = RST_PC;
    m_flush = 0;
    m_mis   = 0;
    defer_addr.delete();
    defer_is_trap = 0;
  endtask

  task automatic model_step();
    bit          want, is_trap, nflush, take_new;
    logic [31:0] t;
    int unsigned align;
    want = 0; is_trap = 0; t = 0; nflush = 0;
    if (trap_i) begin
      want = 1; is_trap = 1; t = trap_vec_i;
    end else if (ctrl_transfer_sel_i == 2'd1) begin
      want = 1; t = tgt_addr_i & 32'hFFFF_FFFE;
    end else if (ctrl_transfer_sel_i == 2'd2 && branch_tkn_i) begin
      want = 1; t = pc_ex_i + offset_i;
    end
`ifdef PC_RVC_EN
    align = 2;
`else
    align = 4;
`endif
    m_mis = want && !is_trap && (t % align != 0);
    if (m_mis) want = 0;
    take_new = want && !(defer_addr.size() != 0 && defer_is_trap && !is_trap);
    case (m_phase)
      PH_BOOT: begin
        if (want) begin m_pc = t; nflush = 1; end
        m_phase = PH_FETCH;
      end
      PH_FETCH: begin
        if (imem_gnt_i) begin
          if (take_new) begin
            m_pc = t; nflush = 1;
          end else if (defer_addr.size() != 0) begin
            m_pc = defer_addr[0]; nflush = 1;
          end else begin
`ifdef PC_RVC_EN
            m_pc = m_pc + (step2_i ? 32'd2 : 32'd4);
`else
            m_pc = m_pc + 32'd4;
`endif
          end
          defer_addr.delete();
          m_phase = stall_i ? PH_HALT : PH_FETCH;
        end else if (take_new) begin
          defer_addr.delete();
          defer_addr.push_back(t);
          defer_is_trap = is_trap;
        end
      end
      default: begin
        if (want) begin m_pc = t; nflush = 1; end
        if (!stall_i) m_phase = PH_FETCH;
      end
    endcase
    m_flush = nflush;
  endtask

  task automatic check_all();
    chk("req",   {31'd0, imem_req_o},   {31'd0, m_phase == PH_FETCH});
    chk("pc",    pc_o,                  m_pc);
    chk("pc4",   pc_plus4_o,            m_pc + 32'd4);
    chk("flush", {31'd0, flush_o},      {31'd0, m_flush});
    chk("mis",   {31'd0, misaligned_o}, {31'd0, m_mis});
  endtask

  // Inputs are set at the falling edge; the model computes the state after
  // the coming rising edge; outputs are compared at the next falling edge.
  task automatic do_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    stall_i = 0; ctrl_transfer_sel_i = 0; branch_tkn_i = 0;
    pc_ex_i = 0; offset_i = 0; tgt_addr_i = 0; trap_i = 0;
    trap_vec_i = 0; step2_i = 0;
  endtask

  initial begin
    rst_n = 0;
    imem_gnt_i = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("rst_pc",    pc_o, RST_PC);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_mis",   {31'd0, misaligned_o}, 32'd0);
    rst_n = 1;

    // Boot with grant tied high: sequential fetch from RESET_ADDR.
    do_cycle(); chk("tp_boot0", pc_o, 32'h100);
    chk("tp_boot_req", {31'd0, imem_req_o}, 32'd1);
    do_cycle(); chk("tp_boot1", pc_o, 32'h104);
    do_cycle(); chk("tp_boot2", pc_o, 32'h108);

    // Jump while grant withheld: PC holds, redirect lands at the grant.
    imem_gnt_i = 0; ctrl_transfer_sel_i = 2'd1; tgt_addr_i = 32'h2001;
    do_cycle(); chk("tp_jhold", pc_o, 32'h108);
    ctrl_transfer_sel_i = 0;
    do_cycle(); do_cycle();
    imem_gnt_i = 1;
    do_cycle(); chk("tp_jpc", pc_o, 32'h2000);
    chk("tp_jflush", {31'd0, flush_o}, 32'd1);
    do_cycle(); chk("tp_jflush_off", {31'd0, flush_o}, 32'd0);

    // Pending branch overwritten by trap.
    imem_gnt_i = 0; ctrl_transfer_sel_i = 2'd2; branch_tkn_i = 1;
    pc_ex_i = 32'h40; offset_i = 32'h20;
    do_cycle();
    ctrl_transfer_sel_i = 0; trap_i = 1; trap_vec_i = 32'h80;
    do_cycle();
    trap_i = 0; imem_gnt_i = 1;
    do_cycle(); chk("tp_bt", pc_o, 32'h80);

    // Pending trap not displaced by later branch.
    imem_gnt_i = 0; trap_i = 1; trap_vec_i = 32'h80;
    do_cycle();
    trap_i = 0; ctrl_transfer_sel_i = 2'd2;
    do_cycle();
    ctrl_transfer_sel_i = 0; imem_gnt_i = 1;
    do_cycle(); chk("tp_tb", pc_o, 32'h80);

    // Stall at completion, jump during HALT, then release.
    stall_i = 1;
    do_cycle(); chk("tp_halt_req", {31'd0, imem_req_o}, 32'd0);
    chk("tp_halt_pc", pc_o, 32'h84);
    ctrl_transfer_sel_i = 2'd1; tgt_addr_i = 32'h300;
    do_cycle(); chk("tp_hjump", pc_o, 32'h300);
    ctrl_transfer_sel_i = 0; stall_i = 0;
    do_cycle(); chk("tp_rel_req", {31'd0, imem_req_o}, 32'd1);
    chk("tp_rel_pc", pc_o, 32'h300);

    // Branch to 0x42.
    ctrl_transfer_sel_i = 2'd2; branch_tkn_i = 1;
    pc_ex_i = 32'h40; offset_i = 32'h2; step2_i = 1;
    do_cycle();
`ifdef PC_RVC_EN
    chk("tp_b42_pc", pc_o, 32'h42);
    chk("tp_b42_mis", {31'd0, misaligned_o}, 32'd0);
    ctrl_transfer_sel_i = 0;
    do_cycle(); chk("tp_step2", pc_o, 32'h44);
`else
    chk("tp_b42_pc", pc_o, 32'h304);
    chk("tp_b42_mis", {31'd0, misaligned_o}, 32'd1);
    ctrl_transfer_sel_i = 0;
    do_cycle(); chk("tp_b42_mis_off", {31'd0, misaligned_o}, 32'd0);
`endif
    step2_i = 0;

    // Asynchronous reset while a request waits, right after a flush.
    ctrl_transfer_sel_i = 2'd1; tgt_addr_i = 32'h500;
    do_cycle();
    ctrl_transfer_sel_i = 0; imem_gnt_i = 0;
    do_cycle();
    chk("ar_pre_req", {31'd0, imem_req_o}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_req",   {31'd0, imem_req_o}, 32'd0);
    chk("ar_pc",    pc_o, RST_PC);
    chk("ar_flush", {31'd0, flush_o}, 32'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      imem_gnt_i          = ($urandom_range(0, 9) < 7);
      stall_i             = ($urandom_range(0, 9) < 2);
      trap_i              = ($urandom_range(0, 19) == 0);
      ctrl_transfer_sel_i = 2'($urandom_range(0, 3));
      branch_tkn_i        = 1'($urandom_range(0, 1));
      step2_i             = 1'($urandom_range(0, 1));
      pc_ex_i             = $urandom & 32'hFFFF_FFFC;
      offset_i            = $urandom;
      if ($urandom_range(0, 3) != 0) offset_i = offset_i & 32'hFFFF_FFFC;
      tgt_addr_i          = $urandom;
      if ($urandom_range(0, 3) != 0) tgt_addr_i = tgt_addr_i & 32'hFFFF_FFFC;
      trap_vec_i          = $urandom & 32'hFFFF_FFFC;
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
